// File: rtl/mc_pulse_sequencer.sv
// mc_pulse_sequencer
// Walks a switch table of cfg_portNum entries. Each entry becomes one output
// pulse of cfg_outWidth cycles on io_Out (cfg_default XOR mask), separated by a
// 2-cycle fetch gap. A pass may end with a delayed feedback pulse, and the whole
// pass repeats cfg_repeat times before a single io_done pulse.
//
// Build option MC_SEQ_FEEDBACK_EN: when defined, the FBDLY/FB stage and io_fbOut
// are included. When undefined, io_fbOut stays low, cfg_fbDelay/cfg_fbWidth are
// ignored, and the last entry of a pass goes straight to the repeat decision.
//
// state | meaning
// IDLE  | waiting for io_trig; io_Out follows cfg_default
// FETCH | tbl_addr = entry index, table read issued
// WAIT  | table data arrives on tbl_data
// OUT   | io_Out = default ^ mask, held for outWidth cycles
// FBDLY | delay between the last entry and the feedback pulse
// FB    | io_fbOut high for fbWidth cycles
// DONE  | one-cycle io_done, then IDLE
module mc_pulse_sequencer #(
   parameter int MAX_PORTS = 64,
   parameter int OUT_W     = 32
) (
   input  logic             io_clk,
   input  logic             io_rst,
   input  logic             io_trig,
   input  logic             io_abort,
   input  logic [5:0]       cfg_portNum,
   input  logic [15:0]      cfg_outWidth,
   input  logic [23:0]      cfg_fbDelay,
   input  logic [15:0]      cfg_fbWidth,
   input  logic [15:0]      cfg_repeat,
   input  logic [OUT_W-1:0] cfg_default,
   output logic [5:0]       tbl_addr,
   input  logic [OUT_W-1:0] tbl_data,
   output logic [OUT_W-1:0] io_Out,
   output logic             io_fbOut,
   output logic             io_busy,
   output logic             io_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_OUT,
      S_FBDLY,
      S_FB,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   state_t           pass_state;
   state_t           tail_state;
   logic [23:0]      cnt_q, cnt_d;
   logic [23:0]      tail_cnt;
   logic             tail_fb;
   logic [5:0]       idx_q, idx_d;
   logic [15:0]      rep_q, rep_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             fb_q, fb_d;
   logic [5:0]       pn_q, pn_d;
   logic [5:0]       pn_lim;
   logic [15:0]      ow_q, ow_d;
   logic [OUT_W-1:0] def_q, def_d;
   logic             last_entry;

`ifdef MC_SEQ_FEEDBACK_EN
   logic [23:0]      fbd_q, fbd_d;
   logic [15:0]      fbw_q, fbw_d;
`else
   logic             unused_fb_cfg;
   assign unused_fb_cfg = ^{cfg_fbDelay, cfg_fbWidth};
`endif

   // A table shallower than the 6-bit address space bounds the entry count.
   assign pn_lim = (int'(cfg_portNum) > MAX_PORTS) ? 6'(MAX_PORTS) : cfg_portNum;

   assign last_entry = ({1'b0, idx_q} + 7'd1) >= {1'b0, pn_q};

   // Repeat decision taken once the entries and feedback of a pass are over.
   assign pass_state = (rep_q > 16'd1) ? S_FETCH : S_DONE;

   // Where a pass goes after its last entry: feedback stage or repeat decision.
   always_comb begin
      tail_state = pass_state;
      tail_cnt   = '0;
      tail_fb    = 1'b0;
`ifdef MC_SEQ_FEEDBACK_EN
      if (fbd_q != 24'd0) begin
         tail_state = S_FBDLY;
         tail_cnt   = fbd_q - 24'd1;
      end else if (fbw_q != 16'd0) begin
         tail_state = S_FB;
         tail_cnt   = {8'd0, fbw_q - 16'd1};
         tail_fb    = 1'b1;
      end
`endif
   end

   // Next-state and datapath logic; abort overrides everything except reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      out_d   = out_q;
      fb_d    = fb_q;
      pn_d    = pn_q;
      ow_d    = ow_q;
      def_d   = def_q;
`ifdef MC_SEQ_FEEDBACK_EN
      fbd_d   = fbd_q;
      fbw_d   = fbw_q;
`endif
      if (state_q != S_IDLE && io_abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         rep_d   = '0;
         out_d   = cfg_default;
         fb_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               out_d = cfg_default;
               fb_d  = 1'b0;
               if (io_trig && !io_abort) begin
                  pn_d    = pn_lim;
                  ow_d    = (cfg_outWidth == 16'd0) ? 16'd1 : cfg_outWidth;
                  rep_d   = (cfg_repeat == 16'd0) ? 16'd1 : cfg_repeat;
                  def_d   = cfg_default;
`ifdef MC_SEQ_FEEDBACK_EN
                  fbd_d   = cfg_fbDelay;
                  fbw_d   = cfg_fbWidth;
`endif
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               if (pn_q == 6'd0) begin
                  state_d = tail_state;
                  cnt_d   = tail_cnt;
                  fb_d    = tail_fb;
                  idx_d   = '0;
                  if (tail_state == S_FETCH) rep_d = rep_q - 16'd1;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               out_d   = def_q ^ tbl_data;
               cnt_d   = {8'd0, ow_q} - 24'd1;
               state_d = S_OUT;
            end
            S_OUT: begin
               if (cnt_q != 24'd0) begin
                  cnt_d = cnt_q - 24'd1;
               end else begin
                  out_d = def_q;
                  if (!last_entry) begin
                     idx_d   = idx_q + 6'd1;
                     state_d = S_FETCH;
                  end else begin
                     state_d = tail_state;
                     cnt_d   = tail_cnt;
                     fb_d    = tail_fb;
                     idx_d   = '0;
                     if (tail_state == S_FETCH) rep_d = rep_q - 16'd1;
                  end
               end
            end
`ifdef MC_SEQ_FEEDBACK_EN
            S_FBDLY: begin
               if (cnt_q != 24'd0) begin
                  cnt_d = cnt_q - 24'd1;
               end else if (fbw_q != 16'd0) begin
                  state_d = S_FB;
                  cnt_d   = {8'd0, fbw_q - 16'd1};
                  fb_d    = 1'b1;
               end else begin
                  state_d = pass_state;
                  idx_d   = '0;
                  if (pass_state == S_FETCH) rep_d = rep_q - 16'd1;
               end
            end
            S_FB: begin
               if (cnt_q != 24'd0) begin
                  cnt_d = cnt_q - 24'd1;
               end else begin
                  fb_d    = 1'b0;
                  state_d = pass_state;
                  idx_d   = '0;
                  if (pass_state == S_FETCH) rep_d = rep_q - 16'd1;
               end
            end
`endif
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge io_clk) begin
      if (io_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         out_q   <= cfg_default;
         fb_q    <= 1'b0;
         pn_q    <= '0;
         ow_q    <= '0;
         def_q   <= '0;
`ifdef MC_SEQ_FEEDBACK_EN
         fbd_q   <= '0;
         fbw_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         out_q   <= out_d;
         fb_q    <= fb_d;
         pn_q    <= pn_d;
         ow_q    <= ow_d;
         def_q   <= def_d;
`ifdef MC_SEQ_FEEDBACK_EN
         fbd_q   <= fbd_d;
         fbw_q   <= fbw_d;
`endif
      end
   end

   assign tbl_addr = idx_q;
   assign io_Out   = out_q;
   assign io_fbOut = fb_q;
   assign io_busy  = (state_q != S_IDLE);
   assign io_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_mc_pulse_sequencer.sv
// Testbench for mc_pulse_sequencer: vector table, hand-written corner cases and
// randomized sequences checked against a timeline model of the pulse train.
`timescale 1ns/1ps
module tb_mc_pulse_sequencer;

`ifdef MC_SEQ_FEEDBACK_EN
   localparam bit FB_EN = 1'b1;
`else
   localparam bit FB_EN = 1'b0;
`endif

   logic        io_clk = 1'b0;
   logic        io_rst, io_trig, io_abort;
   logic [5:0]  cfg_portNum;
   logic [15:0] cfg_outWidth;
   logic [23:0] cfg_fbDelay;
   logic [15:0] cfg_fbWidth;
   logic [15:0] cfg_repeat;
   logic [31:0] cfg_default;
   logic [5:0]  tbl_addr;
   logic [31:0] tbl_data;
   logic [31:0] io_Out;
   logic        io_fbOut, io_busy, io_done;

   logic [31:0] mem [64];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  pn;
      logic [15:0] ow;
      logic [23:0] fbd;
      logic [15:0] fbw;
      logic [15:0] rep;
      logic [31:0] def;
   } cfg_t;

   typedef struct {
      cfg_t c;
      bit   noise;
      int   len_fb;
      int   len_nofb;
      int   fbc_fb;
      int   act;
   } vec_t;

   typedef struct {
      logic [31:0] out;
      logic        fb;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t q[$];

   mc_pulse_sequencer dut (
      .io_clk      (io_clk),
      .io_rst      (io_rst),
      .io_trig     (io_trig),
      .io_abort    (io_abort),
      .cfg_portNum (cfg_portNum),
      .cfg_outWidth(cfg_outWidth),
      .cfg_fbDelay (cfg_fbDelay),
      .cfg_fbWidth (cfg_fbWidth),
      .cfg_repeat  (cfg_repeat),
      .cfg_default (cfg_default),
      .tbl_addr    (tbl_addr),
      .tbl_data    (tbl_data),
      .io_Out      (io_Out),
      .io_fbOut    (io_fbOut),
      .io_busy     (io_busy),
      .io_done     (io_done)
   );

   always #5 io_clk = ~io_clk;

   // switch table with one cycle of read latency
   always @(posedge io_clk) tbl_data <= mem[tbl_addr];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic cfg_t mk_cfg(input int pn, input int ow, input int fbd, input int fbw,
                                   input int rep, input logic [31:0] def);
      cfg_t c;
      c.pn  = 6'(pn);
      c.ow  = 16'(ow);
      c.fbd = 24'(fbd);
      c.fbw = 16'(fbw);
      c.rep = 16'(rep);
      c.def = def;
      return c;
   endfunction

   // Expected per-cycle outputs from the cycle after the trigger up to DONE.
   function automatic void build_model(input cfg_t c);
      int ow;
      int rp;
      exp_t gap;
      exp_t pulse;
      exp_t fbp;
      exp_t dn;
      ow  = (c.ow == 16'd0) ? 1 : int'(c.ow);
      rp  = (c.rep == 16'd0) ? 1 : int'(c.rep);
      gap = '{c.def, 1'b0, 1'b1, 1'b0};
      fbp = '{c.def, 1'b1, 1'b1, 1'b0};
      dn  = '{c.def, 1'b0, 1'b1, 1'b1};
      q.delete();
      for (int p = 0; p < rp; p++) begin
         if (c.pn == 6'd0) q.push_back(gap);
         for (int i = 0; i < int'(c.pn); i++) begin
            q.push_back(gap);
            q.push_back(gap);
            pulse = '{c.def ^ mem[i], 1'b0, 1'b1, 1'b0};
            for (int w = 0; w < ow; w++) q.push_back(pulse);
         end
         if (FB_EN) begin
            for (int d = 0; d < int'(c.fbd); d++) q.push_back(gap);
            for (int w = 0; w < int'(c.fbw); w++) q.push_back(fbp);
         end
      end
      q.push_back(dn);
   endfunction

   task automatic apply_cfg(input cfg_t c);
      cfg_portNum  = c.pn;
      cfg_outWidth = c.ow;
      cfg_fbDelay  = c.fbd;
      cfg_fbWidth  = c.fbw;
      cfg_repeat   = c.rep;
      cfg_default  = c.def;
   endtask

   task automatic trigger();
      @(negedge io_clk);
      io_trig = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int max);
      int k;
      k = 0;
      while (io_busy === 1'b1 && k < max) begin
         @(negedge io_clk);
         io_trig = 1'b0;
         k++;
      end
      chk1(name, io_busy, 1'b0);
   endtask

   // One full sequence compared cycle by cycle with the model; optional noise
   // retriggers and scrambles cfg while busy, which must not change anything.
   task automatic run_seq(input cfg_t c, input bit noise, input string tag,
                          output int len, output int fbc, output int act, output int dn);
      int n;
      exp_t e;
      build_model(c);
      n   = q.size();
      len = 0;
      fbc = 0;
      act = 0;
      dn  = 0;
      apply_cfg(c);
      trigger();
      for (int k = 0; k < n + 2; k++) begin
         @(negedge io_clk);
         io_trig = 1'b0;
         if (k < n) e = q[k];
         else e = '{c.def, 1'b0, 1'b0, 1'b0};
         checks++;
         if ({io_Out, io_fbOut, io_busy, io_done} !== {e.out, e.fb, e.busy, e.done}) begin
            errors++;
            $display("FAIL %s cyc %0d: out=%h fb=%b busy=%b done=%b, expected out=%h fb=%b busy=%b done=%b",
                     tag, k, io_Out, io_fbOut, io_busy, io_done, e.out, e.fb, e.busy, e.done);
         end
         if (io_busy === 1'b1) len++;
         if (io_fbOut === 1'b1) fbc++;
         if (io_Out !== c.def) act++;
         if (io_done === 1'b1) dn++;
         if (noise && k < n) begin
            io_trig      = 1'($urandom_range(0, 1));
            cfg_portNum  = 6'($urandom);
            cfg_outWidth = 16'($urandom);
            cfg_fbDelay  = 24'($urandom);
            cfg_fbWidth  = 16'($urandom);
            cfg_repeat   = 16'($urandom);
         end
      end
      apply_cfg(c);
   endtask

   initial begin
      vec_t vecs[6];
      cfg_t c;
      int   len, fbc, act, dn;

      vecs[0] = '{mk_cfg(4, 5, 3, 2, 1, 32'h0),         1'b0, 34, 29, 2, 20};
      vecs[1] = '{mk_cfg(4, 5, 3, 2, 2, 32'h0),         1'b1, 67, 57, 4, 40};
      vecs[2] = '{mk_cfg(0, 5, 0, 4, 1, 32'h0),         1'b0,  6,  2, 4,  0};
      vecs[3] = '{mk_cfg(2, 0, 0, 0, 0, 32'h0),         1'b0,  7,  7, 0,  2};
      vecs[4] = '{mk_cfg(1, 3, 5, 0, 3, 32'h0),         1'b0, 31, 16, 0,  9};
      vecs[5] = '{mk_cfg(1, 2, 1, 1, 1, 32'hFFFF_FFFF), 1'b0,  7,  5, 1,  2};

      for (int i = 0; i < 64; i++) mem[i] = 32'h1 << (i % 32);
      mem[0] = 32'h10;
      mem[1] = 32'h20;
      mem[2] = 32'h40;
      mem[3] = 32'h80;

      io_rst   = 1'b1;
      io_trig  = 1'b0;
      io_abort = 1'b0;
      apply_cfg(mk_cfg(4, 5, 3, 2, 1, 32'hA5A5_0F0F));
      repeat (3) @(negedge io_clk);
      chk("reset out", io_Out, 32'hA5A5_0F0F);
      chk1("reset fb", io_fbOut, 1'b0);
      chk1("reset busy", io_busy, 1'b0);
      chk1("reset done", io_done, 1'b0);
      chk("reset addr", 32'(tbl_addr), 32'd0);
      io_rst = 1'b0;
      @(negedge io_clk);

      for (int v = 0; v < 6; v++) begin
         run_seq(vecs[v].c, vecs[v].noise, $sformatf("vec%0d", v), len, fbc, act, dn);
         chk($sformatf("vec%0d busy_len", v), len, FB_EN ? vecs[v].len_fb : vecs[v].len_nofb);
         chk($sformatf("vec%0d fb_cycles", v), fbc, FB_EN ? vecs[v].fbc_fb : 0);
         chk($sformatf("vec%0d out_cycles", v), act, vecs[v].act);
         chk($sformatf("vec%0d done_count", v), dn, 1);
      end

      // polarity: mask 0x10 against an all-ones default
      c = mk_cfg(1, 2, 1, 1, 1, 32'hFFFF_FFFF);
      apply_cfg(c);
      trigger();
      repeat (3) begin
         @(negedge io_clk);
         io_trig = 1'b0;
      end
      chk("polarity out", io_Out, 32'hFFFF_FFEF);
      wait_idle("polarity idle", 50);

      // abort in the 3rd OUT cycle of entry 2, then a clean restart
      c = mk_cfg(4, 5, 3, 2, 1, 32'h3);
      apply_cfg(c);
      trigger();
      for (int k = 0; k < 12; k++) begin
         @(negedge io_clk);
         io_trig = 1'b0;
      end
      chk("abort pre out", io_Out, 32'h23);
      io_abort = 1'b1;
      @(negedge io_clk);
      io_abort = 1'b0;
      chk("abort out", io_Out, 32'h3);
      chk1("abort busy", io_busy, 1'b0);
      chk1("abort fb", io_fbOut, 1'b0);
      chk1("abort done", io_done, 1'b0);
      dn = 0;
      repeat (5) begin
         @(negedge io_clk);
         if (io_done === 1'b1) dn++;
      end
      chk("abort no done", dn, 0);
      run_seq(c, 1'b0, "restart", len, fbc, act, dn);
      chk("restart busy_len", len, FB_EN ? 34 : 29);

      // abort and trigger together while busy: abort wins, nothing restarts
      trigger();
      repeat (3) begin
         @(negedge io_clk);
         io_trig = 1'b0;
      end
      io_trig  = 1'b1;
      io_abort = 1'b1;
      @(negedge io_clk);
      io_trig  = 1'b0;
      io_abort = 1'b0;
      chk1("abort+trig busy", io_busy, 1'b0);
      @(negedge io_clk);
      chk1("abort+trig stays idle", io_busy, 1'b0);

      // abort and trigger together in IDLE: no start
      io_trig  = 1'b1;
      io_abort = 1'b1;
      @(negedge io_clk);
      io_trig  = 1'b0;
      io_abort = 1'b0;
      chk1("idle abort+trig", io_busy, 1'b0);

      // reset in the middle of the feedback delay, with trig/abort also high
      c = mk_cfg(4, 5, 10, 2, 1, 32'h00F0_0000);
      apply_cfg(c);
      trigger();
      for (int k = 0; k < 32; k++) begin
         @(negedge io_clk);
         io_trig = 1'b0;
      end
      chk1("pre-reset busy", io_busy, FB_EN);
      io_rst   = 1'b1;
      io_trig  = 1'b1;
      io_abort = 1'b1;
      @(negedge io_clk);
      io_rst   = 1'b0;
      io_trig  = 1'b0;
      io_abort = 1'b0;
      chk("midrst out", io_Out, 32'h00F0_0000);
      chk1("midrst fb", io_fbOut, 1'b0);
      chk1("midrst busy", io_busy, 1'b0);
      chk1("midrst done", io_done, 1'b0);
      chk("midrst addr", 32'(tbl_addr), 32'd0);
      dn = 0;
      repeat (4) begin
         @(negedge io_clk);
         if (io_done === 1'b1 || io_busy === 1'b1) dn++;
      end
      chk("midrst stays idle", dn, 0);

      // randomized configurations and tables
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 8; i++) mem[i] = $urandom;
         c = mk_cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         run_seq(c, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r), len, fbc, act, dn);
         chk($sformatf("rnd%0d done_count", r), dn, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
